// File: rtl/pp_loop_ctrl_if.sv
// Request/status bundle between a pipelined-loop controller and its host.
interface pp_loop_ctrl_if #(
    parameter int unsigned FSM_WIDTH = 2,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DEPTH     = 4
);
    logic                         start;
    logic [CNT_W-1:0]             trip_count;
    logic                         stall;
    logic                         quit_req;
    logic [FSM_WIDTH-1:0]         cur_state;
    logic                         iter_start_enable;
    logic [CNT_W-1:0]             iter_idx;
    logic                         iter_end_enable;
    logic [$clog2(DEPTH+1)-1:0]   inflight;
    logic                         busy;
    logic                         quit_at_end;
    logic                         finish;

    modport master (
        output start, trip_count, stall, quit_req,
        input  cur_state, iter_start_enable, iter_idx, iter_end_enable,
        input  inflight, busy, quit_at_end, finish
    );

    modport slave (
        input  start, trip_count, stall, quit_req,
        output cur_state, iter_start_enable, iter_idx, iter_end_enable,
        output inflight, busy, quit_at_end, finish
    );
endinterface

// File: rtl/pp_loop_ctrl.sv
// Sequencer for one pipelined loop: IDLE/PRE/LOOP/DRAIN, issues an iteration every II
// cycles and tracks in-flight iterations through a DEPTH-stage valid pipe.
module pp_loop_ctrl #(
    parameter int unsigned FSM_WIDTH = 2,
    parameter int unsigned II        = 1,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_W     = 16
) (
    input logic          clock,
    input logic          reset,
    pp_loop_ctrl_if.slave bus
);
    localparam int unsigned IiW  = (II > 1) ? $clog2(II) : 1;
    localparam int unsigned InfW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPre   = 2'd1,
        StLoop  = 2'd2,
        StDrain = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] trip_q, trip_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [IiW-1:0]   ii_q, ii_d;
    logic [DEPTH-1:0] pipe_q, pipe_d;
    logic [InfW-1:0]  inflight_q, inflight_d;
    logic             quit_q, quit_d;
    logic             finish_q, finish_d;
    logic             issue;

    // Quit takes priority over a pending issue in the same cycle.
    assign issue = (state_q == StLoop) && (ii_q == '0) && !bus.stall && !bus.quit_req &&
                   (issued_q < trip_q);

    // FSM next state, trip/issue/II counters, quit flag and finish pulse.
    always_comb begin
        state_d  = state_q;
        trip_d   = trip_q;
        issued_d = issued_q;
        ii_d     = ii_q;
        quit_d   = quit_q;
        finish_d = 1'b0;
        // quit_at_end only qualifies the finish cycle.
        if (finish_q) begin
            quit_d = 1'b0;
        end
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.trip_count != '0) begin
                        trip_d   = bus.trip_count;
                        issued_d = '0;
                        state_d  = StPre;
                    end else begin
                        finish_d = 1'b1;
                    end
                end
            end
            StPre: begin
                ii_d    = '0;
                state_d = StLoop;
            end
            StLoop: begin
                if (bus.quit_req) begin
                    quit_d  = 1'b1;
                    state_d = StDrain;
                end else if (issue) begin
                    issued_d = issued_q + CNT_W'(1);
                    ii_d     = IiW'(II - 1);
                    if (issued_d == trip_q) begin
                        state_d = StDrain;
                    end
                end else if ((ii_q != '0) && !bus.stall) begin
                    ii_d = ii_q - IiW'(1);
                end
            end
            StDrain: begin
                if (pipe_q == '0) begin
                    state_d  = StIdle;
                    finish_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Valid pipe shift (frozen by stall) and its population count.
    always_comb begin
        pipe_d = pipe_q;
        if (!bus.stall) begin
            pipe_d = (pipe_q << 1) | DEPTH'(issue);
        end
        inflight_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inflight_d = inflight_d + InfW'(pipe_d[i]);
        end
    end

    // State register; async reset clears everything so outputs drop immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            trip_q     <= '0;
            issued_q   <= '0;
            ii_q       <= '0;
            pipe_q     <= '0;
            inflight_q <= '0;
            quit_q     <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            trip_q     <= trip_d;
            issued_q   <= issued_d;
            ii_q       <= ii_d;
            pipe_q     <= pipe_d;
            inflight_q <= inflight_d;
            quit_q     <= quit_d;
            finish_q   <= finish_d;
        end
    end

    assign bus.cur_state         = FSM_WIDTH'(state_q);
    assign bus.iter_start_enable = issue;
    assign bus.iter_idx          = issued_q;
    assign bus.iter_end_enable   = pipe_q[DEPTH-1] && !bus.stall;
    assign bus.inflight          = inflight_q;
    assign bus.busy              = (state_q != StIdle);
    assign bus.quit_at_end       = quit_q;
    assign bus.finish            = finish_q;
endmodule

// File: tb/tb_pp_loop_ctrl.sv
// Directed bench for pp_loop_ctrl: expected start/end/finish events are queued when a
// scenario is launched and matched against the DUT by a negedge monitor.
module tb_pp_loop_ctrl;
    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] trip_count = '0;
    logic        stall = 1'b0;
    logic        quit_req = 1'b0;
    logic        sel = 1'b0;

    int errors = 0;
    int checks = 0;
    int gcyc = 0;
    int t0 = 0;

    ev_t exp_s[$];
    int  exp_e[$];
    ev_t exp_f[$];

    always #5 clock = ~clock;
    always @(posedge clock) gcyc <= gcyc + 1;

    pp_loop_ctrl_if #(.FSM_WIDTH(2), .CNT_W(16), .DEPTH(4)) b1 ();
    pp_loop_ctrl_if #(.FSM_WIDTH(2), .CNT_W(16), .DEPTH(4)) b2 ();

    assign b1.start = start;
    assign b1.trip_count = trip_count;
    assign b1.stall = stall;
    assign b1.quit_req = quit_req;
    assign b2.start = start;
    assign b2.trip_count = trip_count;
    assign b2.stall = stall;
    assign b2.quit_req = quit_req;

    pp_loop_ctrl #(.FSM_WIDTH(2), .II(1), .DEPTH(4), .CNT_W(16)) dut1 (
        .clock(clock), .reset(reset), .bus(b1)
    );
    pp_loop_ctrl #(.FSM_WIDTH(2), .II(2), .DEPTH(4), .CNT_W(16)) dut2 (
        .clock(clock), .reset(reset), .bus(b2)
    );

    logic        o_se, o_ee, o_fin, o_quit, o_busy;
    logic [15:0] o_idx;
    logic [1:0]  o_state;
    logic [2:0]  o_inf;
    assign o_se    = sel ? b2.iter_start_enable : b1.iter_start_enable;
    assign o_ee    = sel ? b2.iter_end_enable   : b1.iter_end_enable;
    assign o_fin   = sel ? b2.finish            : b1.finish;
    assign o_quit  = sel ? b2.quit_at_end       : b1.quit_at_end;
    assign o_busy  = sel ? b2.busy              : b1.busy;
    assign o_idx   = sel ? b2.iter_idx          : b1.iter_idx;
    assign o_state = sel ? b2.cur_state         : b1.cur_state;
    assign o_inf   = sel ? b2.inflight          : b1.inflight;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor: every observed event must match the head of its queue.
    always @(negedge clock) begin
        int  rel;
        ev_t e;
        int  ec;
        if (reset) begin
            rel = gcyc - t0;
            if (o_se) begin
                if (exp_s.size() == 0) chk("unexpected_start", 32'(o_se), 0);
                else begin
                    e = exp_s.pop_front();
                    chk("start_cycle", rel, e.cyc);
                    chk("start_idx", 32'(o_idx), e.val);
                end
            end
            if (o_ee) begin
                if (exp_e.size() == 0) chk("unexpected_end", 32'(o_ee), 0);
                else begin
                    ec = exp_e.pop_front();
                    chk("end_cycle", rel, ec);
                end
            end
            if (o_fin) begin
                if (exp_f.size() == 0) chk("unexpected_finish", 32'(o_fin), 0);
                else begin
                    e = exp_f.pop_front();
                    chk("finish_cycle", rel, e.cyc);
                    chk("finish_quit", 32'(o_quit), e.val);
                end
            end
        end
    end

    task automatic push_s(input int c, input int idx);
        ev_t e;
        e.cyc = c;
        e.val = idx;
        exp_s.push_back(e);
    endtask

    task automatic push_f(input int c, input int q);
        ev_t e;
        e.cyc = c;
        e.val = q;
        exp_f.push_back(e);
    endtask

    // Idle gap so both DUTs are back in IDLE, then a one-cycle start at relative cycle 0.
    task automatic launch(input logic s, input int trip);
        repeat (10) @(posedge clock);
        #1;
        sel = s;
        t0 = gcyc;
        start = 1'b1;
        trip_count = 16'(trip);
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Return just after the rising edge that begins relative cycle n.
    task automatic at_cycle(input int n);
        int g = 0;
        do begin
            @(posedge clock);
            #1;
            g++;
        end while ((gcyc - t0) < n && g < 200);
    endtask

    // Return at the falling edge inside relative cycle n.
    task automatic to_cycle(input int n);
        int g = 0;
        do begin
            @(negedge clock);
            g++;
        end while ((gcyc - t0) != n && g < 200);
        if ((gcyc - t0) != n) begin
            checks++;
            errors++;
            $error("FAIL cycle_wait: observed %0d expected %0d", gcyc - t0, n);
        end
    endtask

    task automatic sb_empty(input string tag);
        chk({tag, "_starts_left"}, exp_s.size(), 0);
        chk({tag, "_ends_left"}, exp_e.size(), 0);
        chk({tag, "_finish_left"}, exp_f.size(), 0);
    endtask

    task automatic scen1();
        push_s(2, 0); push_s(3, 1); push_s(4, 2);
        exp_e.push_back(6); exp_e.push_back(7); exp_e.push_back(8);
        push_f(10, 0);
        launch(1'b0, 3);
        to_cycle(1);  chk("s1_pre", 32'(o_state), 1);
        to_cycle(3);  chk("s1_inflight3", 32'(o_inf), 1);
        to_cycle(5);  chk("s1_drain", 32'(o_state), 3);
        chk("s1_inflight5", 32'(o_inf), 3);
        to_cycle(10); chk("s1_idle", 32'(o_state), 0);
        to_cycle(11); chk("s1_quit_after", 32'(o_quit), 0);
        sb_empty("s1");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clock);
        #1;
        chk("rst_state", 32'(b1.cur_state), 0);
        chk("rst_busy", 32'(b1.busy), 0);
        chk("rst_finish", 32'(b1.finish), 0);
        chk("rst_inflight", 32'(b1.inflight), 0);
        @(negedge clock);
        reset = 1'b1;

        // 1: II=1, trip=3
        scen1();

        // 2: II=2, trip=3
        push_s(2, 0); push_s(4, 1); push_s(6, 2);
        exp_e.push_back(6); exp_e.push_back(8); exp_e.push_back(10);
        push_f(12, 0);
        launch(1'b1, 3);
        to_cycle(7);  chk("s2_drain", 32'(o_state), 3);
        to_cycle(13);
        sb_empty("s2");

        // 3: stall during cycles 3-4
        push_s(2, 0); push_s(5, 1); push_s(6, 2);
        exp_e.push_back(8); exp_e.push_back(9); exp_e.push_back(10);
        push_f(12, 0);
        launch(1'b0, 3);
        at_cycle(3);  stall = 1'b1;
        to_cycle(3);  chk("s3_stall_state", 32'(o_state), 2);
        at_cycle(5);  stall = 1'b0;
        to_cycle(5);  chk("s3_inflight", 32'(o_inf), 1);
        to_cycle(13);
        sb_empty("s3");

        // 4: early quit at cycle 4
        push_s(2, 0); push_s(3, 1);
        exp_e.push_back(6); exp_e.push_back(7);
        push_f(9, 1);
        launch(1'b0, 5);
        at_cycle(4);  quit_req = 1'b1;
        at_cycle(5);  quit_req = 1'b0;
        to_cycle(5);  chk("s4_drain", 32'(o_state), 3);
        to_cycle(9);  chk("s4_quit_at_finish", 32'(o_quit), 1);
        to_cycle(10); chk("s4_quit_cleared", 32'(o_quit), 0);
        sb_empty("s4");

        // 5: zero trip count
        push_f(1, 0);
        launch(1'b0, 0);
        to_cycle(1);  chk("s5_state", 32'(o_state), 0);
        chk("s5_busy", 32'(o_busy), 0);
        to_cycle(3);
        sb_empty("s5");

        // 6: reset mid-run at cycle 4, then a clean rerun
        push_s(2, 0); push_s(3, 1); push_s(4, 2);
        launch(1'b0, 3);
        at_cycle(4);
        #2;
        reset = 1'b0;
        #1;
        chk("s6_rst_state", 32'(b1.cur_state), 0);
        chk("s6_rst_start_en", 32'(b1.iter_start_enable), 0);
        chk("s6_rst_idx", 32'(b1.iter_idx), 0);
        chk("s6_rst_end_en", 32'(b1.iter_end_enable), 0);
        chk("s6_rst_inflight", 32'(b1.inflight), 0);
        chk("s6_rst_busy", 32'(b1.busy), 0);
        chk("s6_rst_quit", 32'(b1.quit_at_end), 0);
        chk("s6_rst_finish", 32'(b1.finish), 0);
        exp_s.delete();
        exp_e.delete();
        exp_f.delete();
        @(negedge clock);
        reset = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        chk("s6_post_state", 32'(b1.cur_state), 0);
        sb_empty("s6_abort");
        scen1();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pp_loop_ctrl.md
Name: pp_loop_ctrl

Overview:
- Sequencer for one HLS pipelined loop.
- Walks a 2-bit FSM (IDLE/PRE/LOOP/DRAIN), issues iterations every II cycles and tracks in-flight iterations through a DEPTH-stage valid pipe.
- Reports iteration start/end, early quit and finish.
- Its cur_state/iter_*/quit_at_end/finish outputs drive the same fields the cosim loop monitor samples, so the controller and the monitor agree cycle for cycle.

Parameters:
FSM_WIDTH, 2, state-encoding width; must be >= 2; the upper bits are zero.
II, 1, initiation interval in cycles; must be >= 1.
DEPTH, 4, pipeline depth in stages; must be >= 1.
CNT_W, 16, trip/iteration counter width.

Ports:
clock  in  1  single clock; all flops are rising-edge.
reset  in  1  asynchronous, active-low (0 = reset).
start  in  1  1-cycle request; sampled only in IDLE.
trip_count  in  CNT_W  iteration count, latched on an accepted start.
stall  in  1  freezes issue, the II counter and the valid pipe.
quit_req  in  1  early-exit request; honoured only in LOOP.
cur_state  out  FSM_WIDTH  encoding 0=IDLE, 1=PRE, 2=LOOP, 3=DRAIN.
iter_start_enable  out  1  an iteration issues this cycle.
iter_idx  out  CNT_W  index of the issuing iteration (0-based).
iter_end_enable  out  1  an iteration retires this cycle.
inflight  out  $clog2(DEPTH+1)  population count of the valid pipe.
busy  out  1  cur_state != IDLE.
quit_at_end  out  1  qualifies finish: run ended by quit_req.
finish  out  1  1-cycle completion pulse.

Behaviour:
- Reset (async assert, sync release) clears every flop: state=IDLE, counters=0, pipe=0. All outputs read 0 during reset. Reset mid-run aborts with no finish pulse.
- IDLE:
  - start && trip_count!=0: latch trip_count; next state PRE.
  - start && trip_count==0: stay in IDLE; finish=1 in the next cycle, quit_at_end=0.
  - start while not in IDLE is ignored.
- PRE: lasts exactly one cycle, then LOOP. ii_cnt is cleared to 0.
- LOOP, issue condition: iter_start_enable = (ii_cnt==0) && !stall && !quit_req && (issued < trip).
  - This output is combinational from state and inputs.
  - iter_idx = issued.
- On issue:
  - issued increments.
  - ii_cnt loads II-1.
  - Pipe stage 0 is set at the clock edge.
- Otherwise, ii_cnt decrements when nonzero and !stall.
- LOOP exits to DRAIN in either case:
  - the edge that issues the last iteration (issued becomes trip);
  - any LOOP cycle with quit_req=1. That cycle issues nothing, and quit_at_end is latched to 1.
- quit_req and a pending issue in the same cycle: quit wins.
- Valid pipe: DEPTH bits. Shifts by one per cycle when !stall and holds when stall=1.
  - iter_end_enable = pipe[DEPTH-1] && !stall.
  - End latency is exactly DEPTH unstalled cycles after the start.
- DRAIN: no issue. When the pipe is all-zero, the next state is IDLE.
- finish=1 for exactly the first IDLE cycle after DRAIN, registered. quit_at_end is valid with it and cleared the cycle after.
- Counter rules: issued and the trip compare are CNT_W unsigned with no wrap. Max trip is 2^CNT_W-1.
- Stall has no effect in IDLE or PRE.
- inflight is registered, consistent with the current pipe.

Test Plan:
1. II=1, DEPTH=4, trip=3, start at cycle 0:
   - PRE at cycle 1.
   - iter_start_enable at cycles 2,3,4 with iter_idx 0,1,2.
   - DRAIN from cycle 5.
   - iter_end_enable at cycles 6,7,8.
   - finish=1 only at cycle 10; quit_at_end=0.
2. II=2, DEPTH=4, trip=3: starts at cycles 2,4,6; ends at 6,8,10; finish at cycle 12.
3. II=1, trip=3, stall=1 during cycles 3-4:
   - starts at cycles 2,5,6.
   - iteration 0 ends at cycle 8 (its pipe is frozen 2 cycles).
   - no enable of either kind during the stall.
4. trip=5, quit_req at cycle 4:
   - starts at cycles 2,3 only; DRAIN at cycle 5.
   - ends at cycles 6,7.
   - finish with quit_at_end=1 at cycle 9.
5. trip=0:
   - finish=1 at cycle 1.
   - cur_state stays 0; no start/end enables.
6. Reset low at cycle 4 of scenario 1:
   - all outputs go to 0 immediately, with no clock edge needed.
   - after release, no finish pulse; a new start runs scenario 1 cleanly.
